// File: rtl/gate_lane_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline applying a per-channel bitwise gate to CH lanes of W bits.
// Carries lane parity with each result, counts output handshakes and flags accepted x/z operands.
module gate_lane_pipe #(
   parameter int unsigned CH    = 4,
   parameter int unsigned W     = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH-1:0][W-1:0]  a,
   input  logic [CH-1:0][W-1:0]  b,
   input  logic [CH-1:0][1:0]    mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH-1:0][W-1:0]  y,
   output logic [CH-1:0]         par,
   output logic [15:0]           acc,
   output logic                  xflag
);

   localparam int unsigned ACC_W = 16;

   typedef logic [CH-1:0][W-1:0] lanes_t;

   lanes_t            data_q [DEPTH];
   logic [CH-1:0]     par_q  [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [DEPTH-1:0]  load_c;
   lanes_t            gate_c;
   logic [CH-1:0]     par0_c;
   logic              accept_c;
   logic              out_hs_c;
   logic              x_beat_c;

   // Gate function and lane parity, evaluated on the incoming operands.
   always_comb begin
      logic [W-1:0] g;
      gate_c = '0;
      par0_c = '0;
      g      = '0;
      for (int c = 0; c < int'(CH); c++) begin
         case (mode[c])
            2'b00:   g = a[c] ^ b[c];
            2'b01:   g = a[c] | b[c];
            2'b10:   g = ~a[c];
            2'b11:   g = ~(a[c] ^ b[c]);
            default: g = '0;
         endcase
         gate_c[c] = g;
         par0_c[c] = ^g;
      end
   end

   // A stage may load when it is empty or everything downstream of it can advance.
   always_comb begin
      logic down;
      load_c = '0;
      down   = out_ready;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         down      = !vld_q[i] || down;
         load_c[i] = down;
      end
   end

   assign in_ready  = rst_n && load_c[0];
   assign accept_c  = in_valid && in_ready;
   assign out_hs_c  = vld_q[DEPTH-1] && out_ready;
   assign x_beat_c  = accept_c && (((^a) === 1'bx) || ((^b) === 1'bx));

   assign out_valid = vld_q[DEPTH-1];
   assign y         = data_q[DEPTH-1];
   assign par       = par_q[DEPTH-1];

   // Pipeline stages; data only moves when the source stage holds a valid beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
            par_q[i]  <= '0;
         end
      end else begin
         if (load_c[0]) begin
            vld_q[0] <= accept_c;
            if (accept_c) begin
               data_q[0] <= gate_c;
               par_q[0]  <= par0_c;
            end
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (load_c[i]) begin
               vld_q[i] <= vld_q[i-1];
               if (vld_q[i-1]) begin
                  data_q[i] <= data_q[i-1];
                  par_q[i]  <= par_q[i-1];
               end
            end
         end
      end
   end

   // Handshake counter and sticky unknown flag; clr has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         xflag <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         xflag <= 1'b0;
      end else begin
         if (out_hs_c) acc <= acc + ACC_W'(1);
         if (x_beat_c) xflag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gate_lane_pipe.sv
// Directed bench for gate_lane_pipe: table of gate vectors streamed through a scoreboard,
// plus hand-written sequences for backpressure, x detection, counter wrap, clr and reset.
module tb_gate_lane_pipe;

   localparam int unsigned CH    = 4;
   localparam int unsigned W     = 4;
   localparam int unsigned DEPTH = 2;

   logic                 clk;
   logic                 rst_n;
   logic                 clr;
   logic                 in_valid;
   logic                 in_ready;
   logic [CH-1:0][W-1:0] a;
   logic [CH-1:0][W-1:0] b;
   logic [CH-1:0][1:0]   mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [CH-1:0][W-1:0] y;
   logic [CH-1:0]        par;
   logic [15:0]          acc;
   logic                 xflag;

   gate_lane_pipe #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .par(par), .acc(acc), .xflag(xflag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  mode;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] y;
      logic [3:0]  par;
   } vec_t;

   typedef struct packed {
      logic [15:0] y;
      logic [3:0]  par;
   } exp_t;

   vec_t        tv [6];
   exp_t        sbq [$];
   logic        sb_en;
   logic [15:0] cur_y;
   logic [3:0]  cur_par;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      mode    = tv[i].mode;
      a       = tv[i].a;
      b       = tv[i].b;
      cur_y   = tv[i].y;
      cur_par = tv[i].par;
   endtask

   // Scoreboard: expected results queued at acceptance, checked in order at each output handshake.
   always @(negedge clk) begin
      if (rst_n && sb_en) begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_output", 32'(y), 32'hDEAD);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_y", 32'(y), 32'(e.y));
               chk("sb_par", 32'(par), 32'(e.par));
            end
         end
         if (in_valid && in_ready) sbq.push_back('{y: cur_y, par: cur_par});
      end
   end

   initial begin
      int   nacc;
      logic exp_x;

      // {mode ch3..ch0, a, b, y, par}
      tv[0] = '{8'b00_01_10_11, 16'hA5A5, 16'h0FF0, 16'hAF5A, 4'b0000};
      tv[1] = '{8'b00_00_00_00, 16'h1234, 16'h00FF, 16'h12CB, 4'b1101};
      tv[2] = '{8'b01_01_01_01, 16'h1000, 16'h0300, 16'h1300, 4'b1000};
      tv[3] = '{8'b10_10_10_10, 16'hF0E1, 16'hFFFF, 16'h0F1E, 4'b0011};
      tv[4] = '{8'b11_11_11_11, 16'h0000, 16'h0001, 16'hFFFE, 4'b0001};
      tv[5] = '{8'b11_10_01_00, 16'h738C, 16'h0F4C, 16'h8CC0, 4'b1000};

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; mode = '0; sb_en = 1'b0; cur_y = '0; cur_par = '0;

      // Reset state, inputs ignored while in reset
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_y", 32'(y), 0);
      chk("rst_par", 32'(par), 0);
      chk("rst_acc", 32'(acc), 0);
      chk("rst_xflag", 32'(xflag), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      drive(0); in_valid = 1'b1;
      tick();
      chk("rst_ignores_input", 32'(out_valid), 0);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("idle_in_ready", 32'(in_ready), 1);

      // Single beat: latency and gate function
      sb_en = 1'b1; out_ready = 1'b1;
      drive(0); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_not_early", 32'(out_valid), 0);
      repeat (DEPTH - 1) tick();
      chk("lat_out_valid", 32'(out_valid), 1);
      chk("lat_y", 32'(y), 32'h0000AF5A);
      chk("lat_par", 32'(par), 0);
      tick();
      chk("acc_one", 32'(acc), 1);

      // Stream 20 beats at full rate
      nacc = 0;
      for (int k = 0; k < 20; k++) begin
         drive(k % 6); in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) nacc++;
         tick();
      end
      in_valid = 1'b0;
      chk("stream_accepts", 32'(nacc), 20);
      repeat (DEPTH - 1) tick();
      chk("stream_last_out", 32'(out_valid), 1);
      tick();
      chk("stream_drained", 32'(out_valid), 0);
      chk("stream_acc", 32'(acc), 21);

      // Backpressure: only DEPTH beats fit, output holds stable
      out_ready = 1'b0; nacc = 0;
      for (int k = 0; k < 5; k++) begin
         drive(k); in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) nacc++;
         tick();
      end
      chk("bp_accepts", 32'(nacc), DEPTH);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_y0", 32'(y), 32'(tv[0].y));
      tick(); tick();
      chk("bp_y_stable", 32'(y), 32'(tv[0].y));
      chk("bp_par_stable", 32'(par), 32'(tv[0].par));
      chk("bp_valid_stable", 32'(out_valid), 1);
      // Full pipe, out_ready rising: accept and drain in one cycle
      drive(5); out_ready = 1'b1;
      @(negedge clk);
      chk("bp_same_cycle_accept", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      repeat (DEPTH + 1) tick();
      chk("bp_drained", 32'(out_valid), 0);
      chk("bp_sb_empty", 32'(sbq.size()), 0);
      chk("bp_acc", 32'(acc), 24);
      chk("xflag_clean", 32'(xflag), 0);

      // Unknown operand bit sets the sticky flag
      sb_en = 1'b0;
      drive(0); a[0][1] = 1'bx;
      exp_x = $isunknown(a) || $isunknown(b);
      in_valid = 1'b1;
      tick();
      chk("x_set", 32'(xflag), 32'(exp_x));
      drive(1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("x_sticky", 32'(xflag), 32'(exp_x));
      repeat (DEPTH + 1) tick();
      chk("x_acc", 32'(acc), 26);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_xflag", 32'(xflag), 0);
      chk("clr_acc", 32'(acc), 0);

      // Counter wrap after 65536 handshakes
      drive(0); in_valid = 1'b1;
      repeat (65535) tick();
      in_valid = 1'b0;
      repeat (DEPTH) tick();
      chk("acc_ffff", 32'(acc), 32'h0000FFFF);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (DEPTH) tick();
      chk("acc_wrap", 32'(acc), 0);
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (DEPTH) tick();
      chk("acc_three", 32'(acc), 3);

      // clr wins over a coincident handshake and x beat
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (DEPTH - 1) tick();
      chk("clr_hs_pending", 32'(out_valid), 1);
      drive(0); a[0][1] = 1'bx;
      in_valid = 1'b1; clr = 1'b1;
      tick();
      in_valid = 1'b0; clr = 1'b0;
      chk("clr_wins_acc", 32'(acc), 0);
      chk("clr_wins_xflag", 32'(xflag), 0);
      repeat (DEPTH + 1) tick();
      chk("acc_after_clr", 32'(acc), 1);

      // Asynchronous reset with a full pipe
      drive(2); out_ready = 1'b0; in_valid = 1'b1;
      repeat (DEPTH + 1) tick();
      chk("full_in_ready", 32'(in_ready), 0);
      chk("full_out_valid", 32'(out_valid), 1);
      chk("full_y", 32'(y), 32'(tv[2].y));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_y", 32'(y), 0);
      chk("arst_par", 32'(par), 0);
      chk("arst_acc", 32'(acc), 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      tick();
      chk("arst_hold", 32'(out_valid), 0);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("post_rst_empty", 32'(out_valid), 0);
      sbq.delete();
      sb_en = 1'b1; out_ready = 1'b1;
      drive(3); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_rst_not_early", 32'(out_valid), 0);
      repeat (DEPTH - 1) tick();
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_y", 32'(y), 32'(tv[3].y));
      tick();
      chk("post_rst_acc", 32'(acc), 1);
      chk("final_sb_empty", 32'(sbq.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
